kmc_ucycle_ctl: RTL and testbench

Microcycle controller for the KMC11 microprocessor. It generates the per-cycle enables that drive the KMC11 sequencer: CRAM fetch enable, ALU/register clock enable, PC clock enable and the CRAM write strobe. It implements RUN, single-step, maintenance-instruction execute and CRAM load from the CSR maintenance bits, and it stalls on NPR (DMA) transfers. It sits between the CSR decode and the sequencer/ALU blocks inside the KMC11 top level.

---
 rtl/kmc_ucycle_pkg.sv | 18 +
 rtl/kmc_ucycle_ctl.sv | 142 ++++++++++++++
 tb/tb_kmc_ucycle_ctl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/kmc_ucycle_pkg.sv
// KMC11 microcycle controller: shared state encoding and limits.
// Imported by the controller and anything that decodes its state.
package kmc_ucycle_pkg;

   typedef enum logic [2:0] {
      HALT    = 3'd0,
      FETCH   = 3'd1,
      EXEC    = 3'd2,
      NPRWAIT = 3'd3,
      WB      = 3'd4,
      CWR     = 3'd5
   } ucState_t;

   localparam int EXEC_CYC_MIN = 1;
   localparam int EXEC_CYC_MAX = 7;
   localparam int EXEC_CNT_W   = 3;

endpackage

// File: rtl/kmc_ucycle_ctl.sv
// KMC11 microcycle controller: sequences FETCH/EXEC/WB, single-step,
// maintenance execute, CRAM load and NPR stalls.
module kmc_ucycle_ctl
   import kmc_ucycle_pkg::*;
#(
   parameter int EXEC_CYC   = 1,
   parameter int ICNT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  kmcINIT,
   input  logic                  kmcRUN,
   input  logic                  kmcSTEP,
   input  logic                  kmcCRAMIN,
   input  logic                  kmcCRAMOUT,
   input  logic                  kmcCRAMWRREQ,
   input  logic                  kmcNPRREQ,
   input  logic                  kmcNPRDONE,
   output logic                  kmcCRAMCLKEN,
   output logic                  kmcALUCLKEN,
   output logic                  kmcPCCLKEN,
   output logic                  kmcCRAMWR,
   output logic                  kmcRUNNING,
   output logic                  kmcSTEPDONE,
   output logic [ICNT_WIDTH-1:0] kmcICOUNT
);

   if (EXEC_CYC < EXEC_CYC_MIN || EXEC_CYC > EXEC_CYC_MAX) begin : gBadExecCyc
      $error("kmc_ucycle_ctl: EXEC_CYC out of range 1..7");
   end

   localparam logic [EXEC_CNT_W-1:0] EXEC_LAST = EXEC_CNT_W'(EXEC_CYC - 1);

   ucState_t                state;
   ucState_t                stateNxt;
   logic [EXEC_CNT_W-1:0]   execCnt;
   logic [EXEC_CNT_W-1:0]   execCntNxt;
   logic                    stepMode;
   logic                    stepModeNxt;
   logic                    nprEarly;
   logic                    nprEarlyNxt;
   logic                    stepDone;
   logic                    stepDoneNxt;
   logic [ICNT_WIDTH-1:0]   iCount;
   logic                    init;
   logic                    execLast;
   ucState_t                resumeState;

   assign init     = rst | kmcINIT;
   assign execLast = (execCnt == EXEC_LAST);

   // A maintenance instruction skips the CRAM fetch entirely.
   assign resumeState = kmcCRAMIN ? EXEC : FETCH;

   always_comb begin
      stateNxt    = state;
      execCntNxt  = '0;
      stepModeNxt = stepMode;
      nprEarlyNxt = 1'b0;
      stepDoneNxt = 1'b0;
      unique case (state)
         HALT: begin
            if (kmcCRAMOUT & kmcCRAMWRREQ) begin
               stateNxt = CWR;
            end else if (kmcSTEP & !kmcRUN) begin
               stateNxt    = resumeState;
               stepModeNxt = 1'b1;
            end else if (kmcRUN) begin
               stateNxt = resumeState;
            end
         end
         FETCH: begin
            stateNxt = EXEC;
         end
         EXEC: begin
            if (execLast) begin
               stateNxt    = kmcNPRREQ ? NPRWAIT : WB;
               nprEarlyNxt = kmcNPRREQ & kmcNPRDONE;
            end else begin
               execCntNxt = execCnt + EXEC_CNT_W'(1);
            end
         end
         NPRWAIT: begin
            // nprEarly covers a DONE seen on the clock NPRWAIT was chosen.
            if (kmcNPRDONE | nprEarly) begin
               stateNxt = WB;
            end
         end
         WB: begin
            if (stepMode) begin
               stateNxt    = HALT;
               stepModeNxt = 1'b0;
               stepDoneNxt = 1'b1;
            end else if (kmcRUN) begin
               stateNxt = resumeState;
            end else begin
               stateNxt = HALT;
            end
         end
         CWR: begin
            stateNxt    = HALT;
            stepDoneNxt = 1'b1;
         end
         default: begin
            stateNxt = HALT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (init) begin
         state    <= HALT;
         execCnt  <= '0;
         stepMode <= 1'b0;
         nprEarly <= 1'b0;
         stepDone <= 1'b0;
      end else begin
         state    <= stateNxt;
         execCnt  <= execCntNxt;
         stepMode <= stepModeNxt;
         nprEarly <= nprEarlyNxt;
         stepDone <= stepDoneNxt;
      end
   end

   always_ff @(posedge clk) begin
      if (init) begin
         iCount <= '0;
      end else if (state == WB) begin
         iCount <= iCount + ICNT_WIDTH'(1);
      end
   end

   assign kmcCRAMCLKEN = (state == FETCH);
   assign kmcALUCLKEN  = (state == WB);
   assign kmcPCCLKEN   = (state == WB);
   assign kmcCRAMWR    = (state == CWR);
   assign kmcRUNNING   = (state != HALT);
   assign kmcSTEPDONE  = stepDone;
   assign kmcICOUNT    = iCount;

endmodule

// File: tb/tb_kmc_ucycle_ctl.sv
// Bench for kmc_ucycle_ctl: directed scenarios plus random stimulus
// against a position-in-microcycle reference model.
module tb_kmc_ucycle_ctl;

   localparam int E  = 2;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          kmcINIT;
   logic          kmcRUN;
   logic          kmcSTEP;
   logic          kmcCRAMIN;
   logic          kmcCRAMOUT;
   logic          kmcCRAMWRREQ;
   logic          kmcNPRREQ;
   logic          kmcNPRDONE;
   logic          kmcCRAMCLKEN;
   logic          kmcALUCLKEN;
   logic          kmcPCCLKEN;
   logic          kmcCRAMWR;
   logic          kmcRUNNING;
   logic          kmcSTEPDONE;
   logic [IW-1:0] kmcICOUNT;

   kmc_ucycle_ctl #(
      .EXEC_CYC   (E),
      .ICNT_WIDTH (IW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .kmcINIT      (kmcINIT),
      .kmcRUN       (kmcRUN),
      .kmcSTEP      (kmcSTEP),
      .kmcCRAMIN    (kmcCRAMIN),
      .kmcCRAMOUT   (kmcCRAMOUT),
      .kmcCRAMWRREQ (kmcCRAMWRREQ),
      .kmcNPRREQ    (kmcNPRREQ),
      .kmcNPRDONE   (kmcNPRDONE),
      .kmcCRAMCLKEN (kmcCRAMCLKEN),
      .kmcALUCLKEN  (kmcALUCLKEN),
      .kmcPCCLKEN   (kmcPCCLKEN),
      .kmcCRAMWR    (kmcCRAMWR),
      .kmcRUNNING   (kmcRUNNING),
      .kmcSTEPDONE  (kmcSTEPDONE),
      .kmcICOUNT    (kmcICOUNT)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: whether a microcycle is live, clocks into it, and flags.
   bit mBusy, mCwr, mStep, mDone, mFetch, mHold, mEarly;
   int mPos, mCount;

   int nCram, nAlu, nPc, nWr, nDone;
   logic [12:0] pcMask;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic mStart(input bit stepReq);
      mBusy  = 1;
      mPos   = 0;
      mFetch = !kmcCRAMIN;
      mHold  = 0;
      mEarly = 0;
      mStep  = stepReq;
   endtask

   task automatic modelStep();
      int last;
      last = (mFetch ? 1 : 0) + E;
      if (rst || kmcINIT) begin
         mBusy = 0; mCwr = 0; mStep = 0; mDone = 0;
         mHold = 0; mEarly = 0; mPos = 0; mCount = 0;
      end else if (mCwr) begin
         mCwr  = 0;
         mDone = 1;
      end else if (!mBusy) begin
         mDone = 0;
         if (kmcCRAMOUT && kmcCRAMWRREQ) mCwr = 1;
         else if (kmcSTEP && !kmcRUN) mStart(1);
         else if (kmcRUN) mStart(0);
      end else begin
         mDone = 0;
         if (mPos == last - 1) begin
            mPos++;
            mHold  = kmcNPRREQ;
            mEarly = kmcNPRREQ && kmcNPRDONE;
         end else if (mPos == last && mHold) begin
            if (kmcNPRDONE || mEarly) begin
               mHold  = 0;
               mEarly = 0;
            end
         end else if (mPos == last) begin
            mCount = (mCount + 1) % (1 << IW);
            if (mStep) begin
               mBusy = 0; mStep = 0; mDone = 1;
            end else if (kmcRUN) begin
               mStart(0);
            end else begin
               mBusy = 0;
            end
         end else begin
            mPos++;
         end
      end
   endtask

   task automatic checkAll();
      int  last;
      bit  eCram, eWb;
      last  = (mFetch ? 1 : 0) + E;
      eCram = mBusy && mFetch && mPos == 0;
      eWb   = mBusy && mPos == last && !mHold;
      chk("cramclken", kmcCRAMCLKEN, eCram);
      chk("aluclken", kmcALUCLKEN, eWb);
      chk("pcclken", kmcPCCLKEN, eWb);
      chk("cramwr", kmcCRAMWR, mCwr);
      chk("running", kmcRUNNING, mBusy || mCwr);
      chk("stepdone", kmcSTEPDONE, mDone);
      chk("icount", kmcICOUNT, mCount);
      chk("cram_vs_wr", kmcCRAMCLKEN & kmcCRAMWR, 0);
      chk("pc_wo_alu", kmcPCCLKEN & !kmcALUCLKEN, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkAll();
      nCram += kmcCRAMCLKEN;
      nAlu  += kmcALUCLKEN;
      nPc   += kmcPCCLKEN;
      nWr   += kmcCRAMWR;
      nDone += kmcSTEPDONE;
   endtask

   task automatic clr();
      nCram = 0; nAlu = 0; nPc = 0; nWr = 0; nDone = 0;
   endtask

   task automatic waitHalt(input int lim);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (kmcRUNNING && n < lim);
      if (kmcRUNNING) chk("timeout_halt", 1, 0);
   endtask

   initial begin
      rst = 1; kmcINIT = 0; kmcRUN = 0; kmcSTEP = 0;
      kmcCRAMIN = 0; kmcCRAMOUT = 0; kmcCRAMWRREQ = 0;
      kmcNPRREQ = 0; kmcNPRDONE = 0;
      clr();
      tick();
      rst = 0;
      tick();
      chk("rst_icount", kmcICOUNT, 0);
      chk("rst_running", kmcRUNNING, 0);

      kmcRUN = 1;
      pcMask = '0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (kmcPCCLKEN) pcMask[i] = 1'b1;
      end
      chk("run_pcmask", pcMask, 13'b1_0001_0001_0000);
      kmcRUN = 0;
      waitHalt(40);
      chk("run_icount", kmcICOUNT, 3);

      clr();
      kmcSTEP = 1; tick(); kmcSTEP = 0;
      waitHalt(20);
      chk("step_cram", nCram, 1);
      chk("step_alu", nAlu, 1);
      chk("step_pc", nPc, 1);
      chk("step_done", nDone, 1);
      chk("step_icount", kmcICOUNT, 4);
      tick();

      kmcCRAMIN = 1;
      clr();
      kmcSTEP = 1; tick(); kmcSTEP = 0;
      waitHalt(20);
      kmcCRAMIN = 0;
      chk("mstep_cram", nCram, 0);
      chk("mstep_pc", nPc, 1);
      chk("mstep_icount", kmcICOUNT, 5);
      tick();

      kmcCRAMOUT = 1;
      clr();
      kmcCRAMWRREQ = 1; tick(); kmcCRAMWRREQ = 0;
      waitHalt(10);
      chk("cwr_wr", nWr, 1);
      chk("cwr_done", nDone, 1);
      chk("cwr_pc", nPc, 0);
      chk("cwr_icount", kmcICOUNT, 5);
      kmcRUN = 1;
      tick(); tick();
      clr();
      kmcCRAMWRREQ = 1; tick(); kmcCRAMWRREQ = 0;
      tick(); tick();
      chk("cwr_busy_wr", nWr, 0);
      kmcRUN = 0;
      waitHalt(20);
      kmcCRAMOUT = 0;

      kmcRUN = 1; kmcNPRREQ = 1;
      repeat (4) tick();
      clr();
      for (int i = 0; i < 9; i++) begin
         tick();
         chk("npr_running", kmcRUNNING, 1);
      end
      chk("npr_hold_alu", nAlu, 0);
      chk("npr_hold_cram", nCram, 0);
      kmcNPRDONE = 1; tick(); kmcNPRDONE = 0;
      chk("npr_wb", kmcALUCLKEN, 1);
      repeat (4) tick();
      kmcINIT = 1; tick(); kmcINIT = 0;
      kmcRUN = 0; kmcNPRREQ = 0;
      chk("init_running", kmcRUNNING, 0);
      chk("init_icount", kmcICOUNT, 0);
      chk("init_alu", kmcALUCLKEN, 0);
      chk("init_done", kmcSTEPDONE, 0);

      kmcRUN = 1;
      tick(); tick();
      clr();
      kmcRUN = 0;
      waitHalt(20);
      chk("drop_alu", nAlu, 1);
      chk("drop_icount", kmcICOUNT, 1);

      rst = 1; tick(); rst = 0;
      kmcRUN = 1;
      repeat (64) tick();
      chk("wrap_pre", kmcICOUNT, 15);
      kmcRUN = 0;
      waitHalt(20);
      chk("wrap_icount", kmcICOUNT, 0);

      for (int i = 0; i < 800; i++) begin
         rst          = ($urandom_range(0, 79) == 0);
         kmcINIT      = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 11) == 0) kmcRUN = ~kmcRUN;
         kmcSTEP      = ($urandom_range(0, 7) == 0);
         kmcCRAMIN    = ($urandom_range(0, 3) == 0);
         kmcCRAMOUT   = ($urandom_range(0, 2) == 0);
         kmcCRAMWRREQ = ($urandom_range(0, 5) == 0);
         kmcNPRREQ    = ($urandom_range(0, 2) == 0);
         kmcNPRDONE   = ($urandom_range(0, 3) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
